// File: rtl/rs_gf256_pkg.sv
// GF(256) arithmetic shared by the RS(16,8) encoder and decoder chain (primitive polynomial 0x11D).
// GEN_POLY holds the low eight coefficients of g(x) = prod_{i=1..8} (x + alpha^i); the x^8 term is 1.
package rs_gf256_pkg;

  localparam int SYM_BW = 8;
  localparam int N_NUM  = 16;
  localparam int R_NUM  = 8;
  localparam logic [8:0] PRIM_POLY = 9'h11D;

  typedef logic [SYM_BW-1:0] sym_t;

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } enc_state_e;

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_BW; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYM_BW-1] ? ({sh[SYM_BW-2:0], 1'b0} ^ PRIM_POLY[SYM_BW-1:0])
                        : {sh[SYM_BW-2:0], 1'b0};
    end
    return acc;
  endfunction

  // Expands the product of (x + alpha^i) one root at a time; coefficient k lives at [k*SYM_BW +: SYM_BW].
  function automatic logic [(R_NUM+1)*SYM_BW-1:0] calc_gen_poly();
    logic [(R_NUM+1)*SYM_BW-1:0] g;
    sym_t root;
    g = '0;
    g[SYM_BW-1:0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 1; i <= R_NUM; i++) begin
      root = gf_mul(root, sym_t'(2));
      for (int k = R_NUM; k >= 1; k--) begin
        g[k*SYM_BW +: SYM_BW] = g[(k-1)*SYM_BW +: SYM_BW] ^ gf_mul(g[k*SYM_BW +: SYM_BW], root);
      end
      g[0 +: SYM_BW] = gf_mul(g[0 +: SYM_BW], root);
    end
    return g;
  endfunction

  localparam logic [(R_NUM+1)*SYM_BW-1:0] GEN_POLY_FLAT = calc_gen_poly();

  localparam sym_t GEN_POLY [0:R_NUM-1] = '{
    GEN_POLY_FLAT[7:0],   GEN_POLY_FLAT[15:8],  GEN_POLY_FLAT[23:16], GEN_POLY_FLAT[31:24],
    GEN_POLY_FLAT[39:32], GEN_POLY_FLAT[47:40], GEN_POLY_FLAT[55:48], GEN_POLY_FLAT[63:56]
  };

endpackage

// File: rtl/rs_encoder_16_8_if.sv
// Message-in / codeword-out streams of the RS(16,8) encoder, plus the encoder FSM state for observation.
// Handshake: a symbol moves on a rising edge where valid && ready; once valid is high the source holds
// valid and data (and last/parity) unchanged until that edge, and ready may depend combinationally on valid.
interface rs_encoder_16_8_if #(
  parameter int SYM_BW = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [SYM_BW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_BW-1:0] out_data;
  logic              out_last;
  logic              out_parity;
  rs_gf256_pkg::enc_state_e dbg_state;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_parity, dbg_state
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_parity, dbg_state
  );

endinterface

// File: rtl/rs_enc_lfsr_16_8.sv
// Parity register of the RS(16,8) encoder: divides the message by g(x) as it streams in,
// then shifts the remainder out highest coefficient first.
module rs_enc_lfsr_16_8
  import rs_gf256_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic update,
  input  logic shift,
  input  sym_t din,
  output sym_t par_top
);

  sym_t par_q [R_NUM];
  sym_t fb;

  assign fb      = din ^ par_q[R_NUM-1];
  assign par_top = par_q[R_NUM-1];

  // Shifting in zeros while the parity drains leaves the register clear for the next codeword.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int j = 0; j < R_NUM; j++) par_q[j] <= '0;
    end else if (update) begin
      par_q[0] <= gf_mul(GEN_POLY[0], fb);
      for (int j = 1; j < R_NUM; j++) par_q[j] <= par_q[j-1] ^ gf_mul(GEN_POLY[j], fb);
    end else if (shift) begin
      par_q[0] <= '0;
      for (int j = 1; j < R_NUM; j++) par_q[j] <= par_q[j-1];
    end
  end

endmodule

// File: rtl/rs_encoder_16_8.sv
// Systematic RS(16,8) encoder: forwards 8 message symbols, then appends 8 parity symbols.
// Optional RS_ENC_ABORT_EN adds an abort input that discards the codeword in flight.
module rs_encoder_16_8 #(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 16,
  parameter int R_NUM  = 8
) (
  input logic clk,
  input logic rst,
`ifdef RS_ENC_ABORT_EN
  input logic abort,
`endif
  rs_encoder_16_8_if.slave bus
);

  import rs_gf256_pkg::enc_state_e;
  import rs_gf256_pkg::ST_DATA;
  import rs_gf256_pkg::ST_PARITY;

  localparam int         MSG_NUM  = N_NUM - R_NUM;
  localparam logic [2:0] MSG_LAST = 3'(MSG_NUM - 1);
  localparam logic [2:0] PAR_LAST = 3'(R_NUM - 1);

  enc_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              free, in_ready, accept, emit, kill;
  logic              out_valid_q, out_last_q, out_parity_q;
  logic [SYM_BW-1:0] out_data_q;
  logic [SYM_BW-1:0] par_top;

`ifdef RS_ENC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // The output register is free when empty or being drained this cycle.
  assign free     = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == ST_DATA) && free && !kill;
  assign accept   = bus.in_valid && in_ready;
  assign emit     = (state_q == ST_PARITY) && free && !kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = ST_DATA;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == MSG_LAST) begin
        state_d = ST_PARITY;
        cnt_d   = '0;
      end
    end else if (emit) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == PAR_LAST) begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_parity_q <= 1'b0;
    end else if (kill) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= bus.in_data;
      out_last_q   <= 1'b0;
      out_parity_q <= 1'b0;
    end else if (emit) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= par_top;
      out_last_q   <= (cnt_q == PAR_LAST);
      out_parity_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  rs_enc_lfsr_16_8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clear  (kill),
    .update (accept),
    .shift  (emit),
    .din    (bus.in_data),
    .par_top(par_top)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_parity = out_parity_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_rs_encoder_16_8.sv
// Bench for rs_encoder_16_8: table of messages checked against a long-division reference,
// plus syndrome checks, back-to-back streaming, stalls, mid-codeword reset and (if built) abort.
module tb_rs_encoder_16_8;

  typedef struct packed {
    logic [63:0] msg;
    logic [63:0] par;
    logic        stall;
  } vec_t;

  logic clk;
  logic rst;
`ifdef RS_ENC_ABORT_EN
  logic abort;
`endif

  rs_encoder_16_8_if bus_if ();

  rs_encoder_16_8 dut (
    .clk  (clk),
    .rst  (rst),
`ifdef RS_ENC_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [9:0]  exp_q [$];
  logic [7:0]  exp_t [255];
  logic [7:0]  log_t [256];
  logic [7:0]  g_ref [9];
  logic [7:0]  cw_buf [16];
  bit          rand_ready = 1'b0;
  bit          in_parity  = 1'b0;
  vec_t        vecs [8];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  function automatic logic [63:0] model_parity(input logic [63:0] msg);
    logic [7:0]  r [16];
    logic [7:0]  coef;
    logic [63:0] p;
    for (int k = 0; k < 16; k++) r[k] = 8'h00;
    for (int k = 0; k < 8; k++) r[15-k] = msg[63-8*k -: 8];
    for (int i = 15; i >= 8; i--) begin
      coef = r[i];
      for (int j = 0; j <= 8; j++) r[i-8+j] = r[i-8+j] ^ tb_mul(g_ref[j], coef);
    end
    for (int k = 0; k < 8; k++) p[63-8*k -: 8] = r[7-k];
    return p;
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = 8'(i);
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    log_t[0] = 8'h00;
    for (int k = 0; k < 9; k++) g_ref[k] = 8'h00;
    g_ref[0] = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      for (int k = 8; k >= 1; k--) g_ref[k] = g_ref[k-1] ^ tb_mul(g_ref[k], exp_t[i]);
      g_ref[0] = tb_mul(g_ref[0], exp_t[i]);
    end
    for (int k = 0; k < 16; k++) cw_buf[k] = 8'h00;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_codeword(input logic [63:0] msg, input logic [63:0] par, input int n_par);
    for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, msg[63-8*k -: 8]});
    for (int k = 0; k < n_par; k++)
      exp_q.push_back({(k == 7) ? 1'b1 : 1'b0, 1'b1, par[63-8*k -: 8]});
  endtask

  logic [10:0] held;
  bit          held_valid = 1'b0;

  initial begin
    logic [7:0] s;
    logic [7:0] synd_or;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (bus_if.out_valid && bus_if.out_last) in_parity = 1'b0;
      else if (in_parity) check("in_ready_in_parity", 32'(bus_if.in_ready), 32'd0);
      if (held_valid)
        check("stall_stable",
              32'({bus_if.out_valid, bus_if.out_last, bus_if.out_parity, bus_if.out_data}), 32'(held));
      held_valid = bus_if.out_valid && !bus_if.out_ready;
      held = {bus_if.out_valid, bus_if.out_last, bus_if.out_parity, bus_if.out_data};
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(bus_if.out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_sym", 32'({bus_if.out_last, bus_if.out_parity, bus_if.out_data}), 32'(e));
          for (int k = 0; k < 15; k++) cw_buf[k] = cw_buf[k+1];
          cw_buf[15] = bus_if.out_data;
          if (bus_if.out_last) begin
            synd_or = 8'h00;
            for (int i = 1; i <= 8; i++) begin
              s = 8'h00;
              for (int k = 0; k < 16; k++) s = tb_mul(s, exp_t[i]) ^ cw_buf[k];
              synd_or = synd_or | s;
            end
            check("syndrome", 32'(synd_or), 32'd0);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_sym(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic send_codeword(input logic [63:0] msg, input logic [63:0] par, input int n_par,
                               input bit stall);
    int n;
    push_codeword(msg, par, n_par);
    for (int k = 0; k < 8; k++) begin
      n = stall ? int'($urandom_range(0, 2)) : 0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
      send_sym(msg[63-8*k -: 8]);
    end
    in_parity = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 2000; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Two codewords with in_valid high for every message slot and out_ready held high.
  task automatic stream_two(input logic [63:0] ma, input logic [63:0] pa,
                            input logic [63:0] mb, input logic [63:0] pb);
    logic [63:0] m;
    int k;
    push_codeword(ma, pa, 8);
    push_codeword(mb, pb, 8);
    for (int t = 0; t < 32; t++) begin
      k = t % 16;
      m = (t < 16) ? ma : mb;
      bus_if.in_valid = (k < 8);
      bus_if.in_data  = (k < 8) ? m[63-8*k -: 8] : 8'h00;
      @(negedge clk);
      check("stream_in_ready", 32'(bus_if.in_ready), (k < 8) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      check("stream_out_valid", 32'(bus_if.out_valid), 32'd1);
    end
    bus_if.in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] gpk;
    logic [63:0] m;
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
`ifdef RS_ENC_ABORT_EN
    abort = 1'b0;
`endif
    build_tables();
    for (int k = 0; k < 8; k++) gpk[63-8*k -: 8] = g_ref[7-k];

    vecs[0] = '{msg: 64'h0000_0000_0000_0000, par: 64'h0, stall: 1'b0};
    vecs[1] = '{msg: 64'h0000_0000_0000_0001, par: gpk,   stall: 1'b0};
    vecs[2] = '{msg: 64'h0102_0304_0506_0708, par: 64'h0, stall: 1'b1};
    vecs[3] = '{msg: 64'hFFFF_FFFF_FFFF_FFFF, par: 64'h0, stall: 1'b1};
    vecs[4] = '{msg: 64'h8000_0000_0000_0000, par: 64'h0, stall: 1'b0};
    vecs[5] = '{msg: 64'hA55A_3CC3_0FF0_1234, par: 64'h0, stall: 1'b1};
    vecs[6] = '{msg: 64'h0000_0000_0000_0100, par: 64'h0, stall: 1'b1};
    vecs[7] = '{msg: 64'hDEAD_BEEF_0123_4567, par: 64'h0, stall: 1'b1};
    for (int i = 2; i < 8; i++) vecs[i].par = model_parity(vecs[i].msg);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_data", 32'(bus_if.out_data), 32'd0);
    check("rst_out_last", 32'(bus_if.out_last), 32'd0);
    check("rst_out_parity", 32'(bus_if.out_parity), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

    stream_two(vecs[0].msg, vecs[0].par, vecs[1].msg, vecs[1].par);
    drain();

    for (int i = 0; i < 8; i++) begin
      rand_ready = vecs[i].stall;
      send_codeword(vecs[i].msg, vecs[i].par, 8, vecs[i].stall);
    end
    rand_ready = 1'b0;
    drain();

    m = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 5; k++) exp_q.push_back({2'b00, m[63-8*k -: 8]});
    for (int k = 0; k < 5; k++) send_sym(m[63-8*k -: 8]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus_if.in_ready), 32'd1);
    send_codeword(64'h0F1E_2D3C_4B5A_6978, model_parity(64'h0F1E_2D3C_4B5A_6978), 8, 1'b0);
    drain();

`ifdef RS_ENC_ABORT_EN
    send_codeword(64'h1357_9BDF_2468_ACE0, model_parity(64'h1357_9BDF_2468_ACE0), 3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(bus_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    abort     = 1'b0;
    in_parity = 1'b0;
    check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("abort_in_ready_after", 32'(bus_if.in_ready), 32'd1);
    send_codeword(64'hCAFE_F00D_5A5A_0001, model_parity(64'hCAFE_F00D_5A5A_0001), 8, 1'b0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_encoder_16_8.md
# rs_encoder_16_8

Systematic Reed-Solomon RS(16,8) encoder over GF(256) (primitive polynomial 0x11D, t = 4) at the transmit end of the RS(16,8) datapath. It accepts 8 message symbols on a valid/ready stream and forwards them unchanged. It then appends 8 parity symbols computed by a generator-polynomial LFSR, with g(x) = ∏_{i=1..8}(x + α^i). Its output is the codeword consumed by the syndrome/Berlekamp/Chien/Forney decoder chain.

## Interface
Parameters:
- SYM_BW, 8, symbol width in bits
- N_NUM, 16, codeword length in symbols
- R_NUM, 8, parity symbols per codeword (= 2t)

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- in_valid  in  1  message symbol valid
- in_ready  out  1  encoder accepts a message symbol this cycle
- in_data  in  SYM_BW  message symbol; the first symbol is the coefficient of x^15
- out_valid  out  1  codeword symbol valid
- out_ready  in  1  downstream accepts
- out_data  out  SYM_BW  codeword symbol: c15 first, c0 last
- out_last  out  1  high with the 16th symbol (c0)
- out_parity  out  1  high while out_data is a parity symbol
- abort  in  1  present only with RS_ENC_ABORT_EN

## Operation
- States: DATA (message phase) and PARITY (parity phase). Each state has a 3-bit counter cnt (0..7).
- One-deep registered output stage. The stage is free when `!out_valid || out_ready`.
- in_ready = (state == DATA) && free. This is combinational. in_ready is never high in PARITY.
- DATA accept (in_valid && in_ready):
  - fb = in_data ^ par[7].
  - par[j] <= par[j-1] ^ gf_mul(G[j], fb), with par[-1] = 0.
  - The output register loads in_data with out_parity = 0 and out_last = 0.
  - cnt increments. When cnt == 7, the block enters PARITY with cnt = 0.
- PARITY, stage free:
  - The output register loads par[7] with out_parity = 1, and out_last = (cnt == 7).
  - par shifts up: par[j] <= par[j-1], par[0] <= 0.
  - After cnt == 7 the block returns to DATA with cnt = 0. par is now all-zero.
- No state change without a handshake. Backpressure holds out_data, out_last and out_parity stable while out_valid && !out_ready.
- GF multiply by constant G[j]: the product is reduced mod 0x11D. G[j] is the x^j coefficient of g(x); g is monic (x^8 term implicit).
- Reset: state = DATA, cnt = 0, par = 0, out_valid = 0, out_data = 0, out_last = 0, out_parity = 0. in_ready is therefore 1 in the cycle after reset is released.
- rst mid-codeword: the partial codeword is discarded and nothing further is emitted for it.

## Timing
- Latency: 1 cycle from input accept to out_valid for that symbol.
- Parity c7 is presented the cycle after the 8th message symbol is presented, provided out_ready was high.
- Throughput with out_ready held high: 16 output symbols in 16 consecutive cycles. in_ready is low for the 8 parity cycles.
- A new codeword's first symbol may be accepted in the same cycle c0 leaves the output register. There is no bubble between codewords.
- The LFSR update for the 8th message symbol completes in the same edge as the DATA→PARITY transition. c7 is therefore correct on the first PARITY load.

## Configuration
- RS_ENC_ABORT_EN defined:
  - Adds the abort input.
  - abort high (synchronous, lower priority than rst, higher than any handshake) forces state = DATA, cnt = 0, par = 0, out_valid = 0 on the next edge.
  - in_ready is 0 in the abort cycle.
- Macro undefined: no abort port; behaviour is otherwise identical.

## Structure
- Shared package rs_gf256_pkg holds:
  - SYM_BW, N_NUM, R_NUM and PRIM_POLY = 9'h11D.
  - GEN_POLY[0:7], the g(x) coefficients.
  - A gf_mul function, shared with the decoder blocks.
- Sub-module rs_enc_lfsr_16_8 holds the parity register and its update/shift/clear controls. The top holds the FSM, the counter and the output stage.

## Test plan
- All-zero message, out_ready = 1 → 16 zero symbols in 16 consecutive cycles; out_parity high on symbols 9–16; out_last high only on symbol 16.
- Message 00×7 then 01 → parity c7..c0 = GEN_POLY[7]..GEN_POLY[0].
- Random messages, 1000 codewords:
  - Syndromes c(α^i) = 0 for i = 1..8.
  - Output fed to the decoder chain with ≤4 injected symbol errors → the message is recovered.
- Random out_ready (50%) and random in_valid gaps → codewords match the zero-stall run; out_data is stable while stalled; in_ready is never high in PARITY.
- rst asserted after the 5th message symbol → out_valid = 0 next cycle; the next full message yields the correct codeword with no residue from the partial one.
- With RS_ENC_ABORT_EN: abort during parity symbol 3 → out_valid drops next cycle; in_ready returns to 1; the following codeword is correct.
